// File: rtl/count_mod_updn_if.sv
// ---------------------------------------------------------------------------
// count_mod_updn_if
//   Bundles the control inputs and status outputs of count_mod_updn.
//   master : the side that drives EN/load/up/CNT_In/TOP_In/clr_ovf and
//            observes CNT/TC/OVF.
//   slave  : the counter itself.
//   Signals
//     EN      count enable (gates prescaler and counting)
//     load    synchronous parallel load of CNT_In
//     up      1 = count up, 0 = count down
//     CNT_In  load value (WIDTH)
//     TOP_In  terminal value, count range 0..TOP_In (WIDTH)
//     clr_ovf clears the sticky OVF flag
//     CNT     registered count (WIDTH)
//     TC      registered terminal-count pulse
//     OVF     sticky boundary flag
// ---------------------------------------------------------------------------
interface count_mod_updn_if #(
    parameter int WIDTH = 8
) ();
    logic             EN;
    logic             load;
    logic             up;
    logic [WIDTH-1:0] CNT_In;
    logic [WIDTH-1:0] TOP_In;
    logic             clr_ovf;
    logic [WIDTH-1:0] CNT;
    logic             TC;
    logic             OVF;

    modport master (
        output EN, load, up, CNT_In, TOP_In, clr_ovf,
        input  CNT, TC, OVF
    );

    modport slave (
        input  EN, load, up, CNT_In, TOP_In, clr_ovf,
        output CNT, TC, OVF
    );
endinterface

// File: rtl/count_mod_updn.sv
// ---------------------------------------------------------------------------
// count_mod_updn
//   WIDTH-bit up/down counter with a run-time terminal value, wrap or
//   saturate behaviour at the boundaries, an enable prescaler, a registered
//   terminal-count pulse and a sticky overflow flag.
//   Ports
//     clk  rising-edge clock
//     res  synchronous reset, active-high (clears count, flags, prescaler)
//     bus  count_mod_updn_if.slave (EN, load, up, CNT_In, TOP_In, clr_ovf
//          in; CNT, TC, OVF out, all outputs registered)
//   Parameters
//     WIDTH    counter width (>=2)
//     MODE_SAT 0 = wrap at the boundary, 1 = hold at the boundary
//     PRESCALE enabled cycles per count tick (>=1)
// ---------------------------------------------------------------------------
module count_mod_updn #(
    parameter int WIDTH    = 8,
    parameter int MODE_SAT = 0,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   res,
    count_mod_updn_if.slave        bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_p0;
    logic             tc_p0;
    logic             ovf_p0;
    logic [PW-1:0]    pre_p0;

    logic             tick;
    logic             boundary;
    logic [WIDTH-1:0] cnt_tick;
    logic [PW-1:0]    pre_next;

    // Load values above the terminal are clamped so the count never starts
    // outside 0..TOP_In.
    function automatic logic [WIDTH-1:0] clamp_load(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] top
    );
        return (val > top) ? top : val;
    endfunction

    // Up step: CNT >= TOP (including a TOP lowered below CNT) is a boundary.
    function automatic logic [WIDTH-1:0] step_up(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] top
    );
        if (cnt >= top)
            return (MODE_SAT != 0) ? top : '0;
        return cnt + WIDTH'(1);
    endfunction

    // Down step: a count above TOP resyncs to TOP without being a boundary;
    // only 0 is a boundary.
    function automatic logic [WIDTH-1:0] step_dn(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] top
    );
        if (cnt > top)
            return top;
        if (cnt == '0)
            return (MODE_SAT != 0) ? '0 : top;
        return cnt - WIDTH'(1);
    endfunction

    always_comb begin
        tick     = 1'b0;
        boundary = 1'b0;
        cnt_tick = cnt_p0;
        pre_next = pre_p0;

        tick = bus.EN && (pre_p0 == PRE_LAST);

        if (bus.EN)
            pre_next = (pre_p0 == PRE_LAST) ? '0 : pre_p0 + PW'(1);

        if (bus.up) begin
            boundary = (cnt_p0 >= bus.TOP_In);
            cnt_tick = step_up(cnt_p0, bus.TOP_In);
        end else begin
            boundary = (cnt_p0 == '0);
            cnt_tick = step_dn(cnt_p0, bus.TOP_In);
        end
    end

    // Stage p0: single register stage; priority res > load > tick > hold.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_p0 <= '0;
            tc_p0  <= 1'b0;
            ovf_p0 <= 1'b0;
            pre_p0 <= '0;
        end else if (bus.load) begin
            cnt_p0 <= clamp_load(bus.CNT_In, bus.TOP_In);
            tc_p0  <= 1'b0;
            pre_p0 <= '0;
            if (bus.clr_ovf)
                ovf_p0 <= 1'b0;
        end else begin
            pre_p0 <= pre_next;
            tc_p0  <= tick && boundary;
            if (tick)
                cnt_p0 <= cnt_tick;
            // A boundary on the same edge wins over the clear.
            if (tick && boundary)
                ovf_p0 <= 1'b1;
            else if (bus.clr_ovf)
                ovf_p0 <= 1'b0;
        end
    end

    assign bus.CNT = cnt_p0;
    assign bus.TC  = tc_p0;
    assign bus.OVF = ovf_p0;
endmodule

// File: tb/tb_count_mod_updn.sv
module tb_count_mod_updn;
    logic clk = 1'b0;
    logic res;
    int   checks = 0;
    int   errors = 0;

    always #20 clk = ~clk;

    count_mod_updn_if #(.WIDTH(8)) wi ();
    count_mod_updn_if #(.WIDTH(8)) si ();
    count_mod_updn_if #(.WIDTH(8)) pi ();

    count_mod_updn #(.WIDTH(8), .MODE_SAT(0), .PRESCALE(1)) dut_w (
        .clk(clk), .res(res), .bus(wi)
    );
    count_mod_updn #(.WIDTH(8), .MODE_SAT(1), .PRESCALE(1)) dut_s (
        .clk(clk), .res(res), .bus(si)
    );
    count_mod_updn #(.WIDTH(8), .MODE_SAT(0), .PRESCALE(3)) dut_p (
        .clk(clk), .res(res), .bus(pi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        res = 1'b1;
        wi.EN = 0; wi.load = 0; wi.up = 1; wi.CNT_In = 0; wi.TOP_In = 8'hFF; wi.clr_ovf = 0;
        si.EN = 0; si.load = 0; si.up = 1; si.CNT_In = 0; si.TOP_In = 8'hFF; si.clr_ovf = 0;
        pi.EN = 0; pi.load = 0; pi.up = 1; pi.CNT_In = 0; pi.TOP_In = 8'hFF; pi.clr_ovf = 0;

        // reset
        step();
        chk("rst_w_cnt", 32'(wi.CNT), 32'h0);
        chk("rst_w_tc",  32'(wi.TC),  32'h0);
        chk("rst_w_ovf", 32'(wi.OVF), 32'h0);
        chk("rst_s_cnt", 32'(si.CNT), 32'h0);
        chk("rst_p_cnt", 32'(pi.CNT), 32'h0);

        // free count up with TOP=FF
        res = 1'b0; wi.EN = 1;
        step(); chk("up_1", 32'(wi.CNT), 32'h1);
        step(); chk("up_2", 32'(wi.CNT), 32'h2);
        step(); chk("up_3", 32'(wi.CNT), 32'h3);

        // wrap at TOP=5
        wi.load = 1; wi.CNT_In = 8'h00; wi.TOP_In = 8'h05;
        step(); chk("wrap_load0", 32'(wi.CNT), 32'h0);
        wi.load = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("wrap_cnt", 32'(wi.CNT), 32'(i));
            chk("wrap_tc0", 32'(wi.TC), 32'h0);
        end
        step();
        chk("wrap_cnt0", 32'(wi.CNT), 32'h0);
        chk("wrap_tc1",  32'(wi.TC),  32'h1);
        chk("wrap_ovf1", 32'(wi.OVF), 32'h1);
        step();
        chk("wrap_cnt1",  32'(wi.CNT), 32'h1);
        chk("wrap_tc_lo", 32'(wi.TC),  32'h0);
        chk("wrap_ovf_s", 32'(wi.OVF), 32'h1);
        wi.clr_ovf = 1;
        step();
        chk("clr_cnt2", 32'(wi.CNT), 32'h2);
        chk("clr_ovf0", 32'(wi.OVF), 32'h0);
        wi.clr_ovf = 0;

        // load with EN=0, hold, clamped load
        wi.EN = 0; wi.load = 1; wi.CNT_In = 8'h11; wi.TOP_In = 8'hFF;
        step(); chk("load_11", 32'(wi.CNT), 32'h11);
        wi.load = 0;
        for (int i = 0; i < 5; i++) begin
            step(); chk("hold_11", 32'(wi.CNT), 32'h11);
        end
        wi.load = 1; wi.CNT_In = 8'h30; wi.TOP_In = 8'h20;
        step(); chk("load_clamp", 32'(wi.CNT), 32'h20);
        wi.load = 0;

        // down counting, resync, direction change, TOP=0
        wi.EN = 1; wi.up = 0;
        step(); chk("dn_1f", 32'(wi.CNT), 32'h1F); chk("dn_1f_tc", 32'(wi.TC), 32'h0);
        wi.TOP_In = 8'h10;
        step(); chk("dn_resync", 32'(wi.CNT), 32'h10); chk("dn_resync_tc", 32'(wi.TC), 32'h0);
        wi.up = 1; wi.TOP_In = 8'h05;
        step(); chk("up_lowtop", 32'(wi.CNT), 32'h0); chk("up_lowtop_tc", 32'(wi.TC), 32'h1);
        chk("up_lowtop_ovf", 32'(wi.OVF), 32'h1);
        wi.up = 0;
        step(); chk("dn_wrap", 32'(wi.CNT), 32'h5); chk("dn_wrap_tc", 32'(wi.TC), 32'h1);
        wi.TOP_In = 8'h00;
        step(); chk("top0_resync", 32'(wi.CNT), 32'h0); chk("top0_resync_tc", 32'(wi.TC), 32'h0);
        step(); chk("top0_dn", 32'(wi.CNT), 32'h0); chk("top0_dn_tc", 32'(wi.TC), 32'h1);
        wi.up = 1;
        step(); chk("top0_up", 32'(wi.CNT), 32'h0); chk("top0_up_tc", 32'(wi.TC), 32'h1);
        wi.EN = 0;

        // saturate mode, down
        si.load = 1; si.CNT_In = 8'h02; si.up = 0;
        step(); chk("sat_load2", 32'(si.CNT), 32'h2);
        si.load = 0; si.EN = 1;
        step(); chk("sat_1", 32'(si.CNT), 32'h1); chk("sat_1_tc", 32'(si.TC), 32'h0);
        step(); chk("sat_0", 32'(si.CNT), 32'h0); chk("sat_0_tc", 32'(si.TC), 32'h0);
        chk("sat_0_ovf", 32'(si.OVF), 32'h0);
        step(); chk("sat_h1", 32'(si.CNT), 32'h0); chk("sat_h1_tc", 32'(si.TC), 32'h1);
        chk("sat_h1_ovf", 32'(si.OVF), 32'h1);
        si.clr_ovf = 1;
        step(); chk("sat_h2", 32'(si.CNT), 32'h0); chk("sat_h2_tc", 32'(si.TC), 32'h1);
        chk("sat_clr_lose", 32'(si.OVF), 32'h1);
        si.EN = 0;
        step(); chk("sat_clr", 32'(si.OVF), 32'h0); chk("sat_idle_tc", 32'(si.TC), 32'h0);
        si.clr_ovf = 0;
        // saturate mode, up at TOP
        si.TOP_In = 8'h03; si.load = 1; si.CNT_In = 8'h03; si.up = 1;
        step(); chk("satu_load", 32'(si.CNT), 32'h3);
        si.load = 0; si.EN = 1;
        step(); chk("satu_hold", 32'(si.CNT), 32'h3); chk("satu_tc", 32'(si.TC), 32'h1);
        chk("satu_ovf", 32'(si.OVF), 32'h1);
        si.EN = 0;

        // prescaler = 3 with an EN pause mid-prescale
        pi.EN = 1;
        step(); chk("ps_a", 32'(pi.CNT), 32'h0);
        step(); chk("ps_b", 32'(pi.CNT), 32'h0);
        step(); chk("ps_c", 32'(pi.CNT), 32'h1); chk("ps_c_tc", 32'(pi.TC), 32'h0);
        step(); chk("ps_d", 32'(pi.CNT), 32'h1);
        pi.EN = 0;
        step(); chk("ps_frz1", 32'(pi.CNT), 32'h1);
        step(); chk("ps_frz2", 32'(pi.CNT), 32'h1);
        pi.EN = 1;
        step(); chk("ps_e", 32'(pi.CNT), 32'h1);
        step(); chk("ps_f", 32'(pi.CNT), 32'h2);

        // reset together with load, mid-count and mid-prescale
        wi.load = 1; wi.CNT_In = 8'h40; wi.TOP_In = 8'hFF;
        step(); chk("r_load40", 32'(wi.CNT), 32'h40);
        wi.load = 0; wi.EN = 1; wi.up = 1;
        step(); chk("r_41", 32'(wi.CNT), 32'h41);
        res = 1; wi.load = 1; wi.CNT_In = 8'h44;
        step();
        chk("r_cnt", 32'(wi.CNT), 32'h0);
        chk("r_tc",  32'(wi.TC),  32'h0);
        chk("r_ovf", 32'(wi.OVF), 32'h0);
        chk("r_pcnt", 32'(pi.CNT), 32'h0);
        res = 0; wi.load = 0;
        step(); chk("r_w1", 32'(wi.CNT), 32'h1); chk("r_p1", 32'(pi.CNT), 32'h0);
        step(); chk("r_w2", 32'(wi.CNT), 32'h2); chk("r_p2", 32'(pi.CNT), 32'h0);
        step(); chk("r_w3", 32'(wi.CNT), 32'h3); chk("r_p3", 32'(pi.CNT), 32'h1);
        wi.TOP_In = 8'h01;
        step();
        chk("drop_cnt", 32'(wi.CNT), 32'h0);
        chk("drop_tc",  32'(wi.TC),  32'h1);
        chk("drop_ovf", 32'(wi.OVF), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
